// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the round-robin serial frame detector scheduler.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int                     DEF_FRAME_W = 4;
  localparam logic [DEF_FRAME_W-1:0] DEF_PATTERN = 4'b0110;
  localparam int                     STAT_W      = 8;

endpackage

// File: rtl/serial_frame_matcher.sv
// Serial MSB-first frame comparator; hit pulses the cycle after the last bit
// of a frame whose bits equal PATTERN.
module serial_frame_matcher
  import seq_sched_pkg::*;
#(
  parameter int                   FRAME_W = DEF_FRAME_W,
  parameter logic [FRAME_W-1:0]   PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic bit_valid,
  input  logic bit_in,
  output logic hit
);

  localparam int CW = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      prior;
  logic               hit_q, hit_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    rx_d  = rx_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    prior = frame_start ? '0 : cnt_q;
    if (bit_valid) begin
      rx_d  = (rx_q << 1) | FRAME_W'(bit_in);
      // Count sticks at FRAME_W so stray bits after a frame cannot re-fire hit.
      cnt_d = (prior == CW'(FRAME_W)) ? prior : prior + CW'(1);
      hit_d = (prior == CW'(FRAME_W - 1)) && (rx_d == PATTERN);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q  <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial frame matcher among NREQ requesters.
// Optional match statistics counter: define SEQ_DETECT_SCHED_STATS_EN.
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int                 NREQ    = 4,
  parameter int                 FRAME_W = DEF_FRAME_W,
  parameter logic [FRAME_W-1:0] PATTERN = DEF_PATTERN,
  parameter int                 ID_W    = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*FRAME_W-1:0] data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
`ifdef SEQ_DETECT_SCHED_STATS_EN
  input  logic                    clr_count,
  output logic [STAT_W-1:0]       match_count,
`endif
  output logic                    match
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic               any_req;
  logic [ID_W-1:0]    winner;
  logic               bit_valid, frame_start, hit;

  // Rotating priority: first requester at or after rr_q+1, wrapping at NREQ.
  always_comb begin
    any_req = 1'b0;
    winner  = rr_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_req && req[(int'(rr_q) + k) % NREQ]) begin
        any_req = 1'b1;
        winner  = ID_W'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SHIFT;
          shift_d = data[int'(winner)*FRAME_W +: FRAME_W];
          cnt_d   = '0;
          rr_d    = winner;
        end
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      rr_q    <= ID_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  assign bit_valid   = (state_q == SHIFT);
  assign frame_start = bit_valid && (cnt_q == '0);

  serial_frame_matcher #(
    .FRAME_W (FRAME_W),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (shift_q[FRAME_W-1]),
    .hit         (hit)
  );

  // Grant is the first SHIFT cycle, decoded from the pointer just loaded.
  always_comb begin
    gnt = '0;
    if (frame_start) gnt[rr_q] = 1'b1;
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == REPORT);
  assign match   = done & hit;
  assign done_id = done ? rr_q : '0;

`ifdef SEQ_DETECT_SCHED_STATS_EN
  logic [STAT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_count)                   count_d = '0;
    else if (match && count_q != '1) count_d = count_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: directed scenarios plus random
// traffic against a transaction-timeline reference model.
module tb_seq_detect_sched;

  localparam int               NREQ = 4;
  localparam int               FW   = 4;
  localparam int               ID_W = 2;
  localparam logic [FW-1:0]    PAT  = 4'b0110;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*FW-1:0]   data = '0;
  logic [NREQ-1:0]      gnt;
  logic                 busy, done, match;
  logic [ID_W-1:0]      done_id;
`ifdef SEQ_DETECT_SCHED_STATS_EN
  logic                 clr_count = 1'b0;
  logic [7:0]           match_count;
  int                   m_cnt;
`endif

  seq_detect_sched #(.NREQ(NREQ), .FRAME_W(FW), .PATTERN(PAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .gnt         (gnt),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
`ifdef SEQ_DETECT_SCHED_STATS_EN
    .clr_count   (clr_count),
    .match_count (match_count),
`endif
    .match       (match)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit auto_drop = 1'b1;

  // Reference model: cycles elapsed since the last grant (0 = idle).
  int            m_t;
  int            m_ptr;
  logic [FW-1:0] m_frame;

  int gnt_id_q[$], gnt_cyc_q[$], done_id_q[$], done_cyc_q[$], done_m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t   = 0;
    m_ptr = NREQ - 1;
`ifdef SEQ_DETECT_SCHED_STATS_EN
    m_cnt = 0;
`endif
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
`ifdef SEQ_DETECT_SCHED_STATS_EN
    if (clr_count) m_cnt = 0;
    else if (m_t == FW + 1 && m_frame == PAT && m_cnt < 255) m_cnt++;
`endif
    if (m_t == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx = (m_ptr + k) % NREQ;
        if (m_t == 0 && req[idx]) begin
          m_ptr   = idx;
          m_frame = data[idx*FW +: FW];
          m_t     = 1;
        end
      end
    end else if (m_t == FW + 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NREQ-1:0] e_gnt;
    logic            e_done;
    e_gnt  = (m_t == 1) ? (NREQ'(1) << m_ptr) : '0;
    e_done = (m_t == FW + 1);
    check({tag, ":gnt"},   gnt,   e_gnt);
    check({tag, ":busy"},  busy,  m_t != 0);
    check({tag, ":done"},  done,  e_done);
    check({tag, ":match"}, match, e_done && (m_frame == PAT));
    if (e_done) check({tag, ":done_id"}, done_id, m_ptr);
`ifdef SEQ_DETECT_SCHED_STATS_EN
    check({tag, ":count"}, match_count, m_cnt);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_outputs($sformatf("c%0d", cyc));
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_id_q.push_back(i);
        gnt_cyc_q.push_back(cyc);
      end
    end
    if (done) begin
      done_id_q.push_back(int'(done_id));
      done_cyc_q.push_back(cyc);
      done_m_q.push_back(int'(match));
    end
  endtask

  task automatic clear_logs();
    gnt_id_q.delete(); gnt_cyc_q.delete();
    done_id_q.delete(); done_cyc_q.delete(); done_m_q.delete();
  endtask

  task automatic run(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      cycle();
      if (auto_drop && m_t == 1) req[m_ptr] = 1'b0;
      if (rnd) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i] && $urandom_range(3) == 0) begin
            req[i] = 1'b1;
            data[i*FW +: FW] = $urandom_range(1) ? PAT : FW'($urandom);
          end else if (req[i] && $urandom_range(15) == 0) begin
            req[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    model_reset();
    check_outputs("reset");
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int t0;
    model_reset();
    m_frame = '0;
    apply_reset();

    // Single matching requester: gnt at +1, done at +1+FW.
    req = 4'b0001; data[3:0] = 4'b0110; t0 = cyc;
    run(8, 0);
    check("single:ngnt", gnt_id_q.size(), 1);
    check("single:ndone", done_id_q.size(), 1);
    if (gnt_id_q.size() > 0) begin
      check("single:gnt_id", gnt_id_q[0], 0);
      check("single:gnt_lat", gnt_cyc_q[0] - t0, 1);
    end
    if (done_id_q.size() > 0) begin
      check("single:done_lat", done_cyc_q[0] - t0, 5);
      check("single:done_id", done_id_q[0], 0);
      check("single:match", done_m_q[0], 1);
    end

    // Non-matching frames, including the bit-reversed neighbour.
    clear_logs();
    req = 4'b0100; data[11:8] = 4'b0111;
    run(8, 0);
    req = 4'b0100; data[11:8] = 4'b1110;
    run(8, 0);
    check("nomatch:ndone", done_id_q.size(), 2);
    if (done_id_q.size() == 2) begin
      check("nomatch:id0", done_id_q[0], 2);
      check("nomatch:m0", done_m_q[0], 0);
      check("nomatch:id1", done_id_q[1], 2);
      check("nomatch:m1", done_m_q[1], 0);
    end

    // Full contention from reset: 0,1,2,3 spaced FW+2 apart.
    apply_reset();
    req = 4'b1111; data = {4{4'b0110}};
    run(30, 0);
    check("contend:ngnt", gnt_id_q.size(), 4);
    check("contend:ndone", done_id_q.size(), 4);
    if (gnt_id_q.size() == 4 && done_id_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("contend:gnt%0d", i), gnt_id_q[i], i);
        check($sformatf("contend:done%0d", i), done_id_q[i], i);
        check($sformatf("contend:m%0d", i), done_m_q[i], 1);
        if (i > 0) check($sformatf("contend:gap%0d", i), gnt_cyc_q[i] - gnt_cyc_q[i-1], FW + 2);
      end
    end

    // Fairness: req[0] never drops, req[2] joins at cycle 3.
    apply_reset();
    auto_drop = 1'b0;
    req = 4'b0001; data = '0; data[3:0] = 4'b0110; data[11:8] = 4'b1010;
    run(3, 0);
    req[2] = 1'b1;
    run(30, 0);
    check("fair:ngnt", gnt_id_q.size() >= 4, 1);
    if (gnt_id_q.size() >= 4) begin
      check("fair:g0", gnt_id_q[0], 0);
      check("fair:g1", gnt_id_q[1], 2);
      check("fair:g2", gnt_id_q[2], 0);
      check("fair:g3", gnt_id_q[3], 2);
    end
    auto_drop = 1'b1;
    req = '0;
    run(8, 0);

    // Reset in the second SHIFT cycle of requester 1.
    apply_reset();
    req = 4'b0010; data = '0; data[7:4] = 4'b0110;
    run(2, 0);
    check("midrst:busy_before", busy, 1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("midrst_async");
    clear_logs();
    cycle();
    cycle();
    rst = 1'b0;
    req = 4'b0011; data[3:0] = 4'b0111; data[7:4] = 4'b0110;
    run(10, 0);
    check("midrst:ndone", done_id_q.size(), 1);
    if (gnt_id_q.size() > 0) check("midrst:first_gnt", gnt_id_q[0], 0);
    if (done_id_q.size() > 0) check("midrst:first_done", done_id_q[0], 0);
    req = '0;
    run(10, 0);

    // Random traffic against the model.
    apply_reset();
    run(2000, 1);
    req = '0;
    run(10, 0);

`ifdef SEQ_DETECT_SCHED_STATS_EN
    // 260 matching frames saturate the counter; clr wins over a match.
    apply_reset();
    auto_drop = 1'b0;
    req = 4'b0001; data = '0; data[3:0] = PAT;
    run(260 * (FW + 2) + 6, 0);
    check("stats:sat", match_count, 8'd255);
    for (int k = 0; k < 12 && m_t != FW + 1; k++) run(1, 0);
    check("stats:at_done", m_t, FW + 1);
    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0;
    check("stats:clr", match_count, 8'd0);
    auto_drop = 1'b1;
    req = '0;
    run(10, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Round-robin scheduler that shares one serial frame-pattern detector among NREQ requesters.
- Each requester presents a FRAME_W-bit parallel frame. The block grants one requester, shifts its frame MSB-first into the detector, and returns a tagged match/no-match result.
- Sits between the parallel frame producers and the serial detector datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FRAME_W, 4, bits per frame.
- PATTERN, 4'b0110, frame value that counts as a match (FRAME_W bits).
- ID_W, $clog2(NREQ), width of the requester index.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held until granted.
- data  in  NREQ*FRAME_W  frames; requester i occupies bits [i*FRAME_W +: FRAME_W]; held stable while req[i]=1.
- gnt  out  NREQ  one-hot, 1-cycle pulse; data of the granted requester is captured in this cycle.
- busy  out  1  high from grant cycle through result cycle.
- done  out  1  1-cycle result strobe.
- done_id  out  ID_W  index of the requester whose frame produced done.
- match  out  1  valid when done=1; 1 if frame==PATTERN.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-high.
  - On rst=1, immediately and independent of clk: state=IDLE, gnt=0, busy=0, done=0, done_id=0, match=0, shift register=0, bit counter=0, rr pointer=NREQ-1 (req[0] has highest priority first).
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - If any req bit is 1 at an edge, pick the first requester set at or after rr_ptr+1 (modulo NREQ).
  - Next cycle: state=SHIFT, gnt[winner]=1 for exactly that cycle, busy=1, frame loaded into the shift register, rr_ptr=winner, counter=0.
  - With no req, stay in IDLE with all strobes 0.
- SHIFT:
  - Present shift_reg[FRAME_W-1] to the detector with bit_valid=1. Shift left each cycle; counter increments.
  - After FRAME_W cycles (counter==FRAME_W-1), go to REPORT.
  - gnt is high only in the first SHIFT cycle.
- REPORT:
  - done=1, match=detector result, done_id=rr_ptr, busy=1 for one cycle.
  - Next state is IDLE. Requests are not sampled during REPORT.
- Latency and throughput:
  - req first seen in IDLE at cycle N gives gnt at N+1 and done at N+1+FRAME_W.
  - Back-to-back grants are spaced FRAME_W+2 cycles apart.
- Frame alignment: the detector is restarted at every grant (frame_start pulse in the first SHIFT cycle), so frames never overlap and no residual state carries between requesters.
- Requester changes:
  - A requester may drop req before being granted; it is simply skipped.
  - A requester may drop req or change data the cycle after its gnt; the frame is already captured.
- Simultaneous requests: resolved purely by rotating priority. No requester waits more than NREQ-1 grants.
- Reset mid-operation: the frame in flight is aborted; no done is produced for it; the rr pointer returns to NREQ-1.
- Unused data/req bits must never produce X on outputs; default case returns to IDLE.

Optional Feature:
- Macro: SEQ_DETECT_SCHED_STATS_EN.
- When defined:
  - Adds output match_count (8 bits). It increments on every done with match=1 and saturates at 255.
  - Adds input clr_count (1 bit). clr_count=1 zeroes the counter synchronously and has priority over increment in the same cycle.
  - rst zeroes the counter.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Package seq_sched_pkg holds:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, REPORT=2'd2);
  - default FRAME_W and PATTERN;
  - the counter width for the stats counter.
- One sub-module, serial_frame_matcher:
  - Inputs: clk, rst, frame_start, bit_valid, bit_in.
  - Output: hit. Registered; high in the cycle after the FRAME_W-th bit iff the bits, in order, equal PATTERN MSB-first.
  - frame_start forces the matcher to its first-bit state.
- The scheduler owns arbitration, the shift register, the counter and result tagging.

Test Plan:
- Single requester: req[0]=1, data[3:0]=0110 at cycle 0 -> gnt=0001 at cycle 1; done=1, match=1, done_id=0 at cycle 5.
- No match: req[2]=1, frame 0111 -> gnt=0100; done after 4 SHIFT cycles with match=0, done_id=2. Repeat with 1110 -> match=0 (bit order check).
- Full contention: req=1111, all frames 0110, held until granted -> grants in order 0,1,2,3, six cycles apart; four done pulses with done_id 0..3, all match=1.
- Fairness: req[0] held high continuously, req[2] asserted at cycle 3 -> grants alternate 0,2,0,2; req[2] is never starved.
- Reset mid-frame: assert rst during the 2nd SHIFT cycle of requester 1 -> all outputs 0 immediately, no done pulse; after release with req=0011, the next grant goes to requester 0.
- With SEQ_DETECT_SCHED_STATS_EN: 260 matching frames -> match_count stops at 255; clr_count coinciding with a match done -> count 0.
